// File: rtl/rhd_miso_deserializer.sv
// rhd_miso_deserializer
// Host-side receive stage for the headstage MISO lines. SCLK, CS and every
// MISO line are oversampled in the clk domain. The MISO sample point is
// pushed back by a programmable number of clk cycles to absorb cable and
// headstage delay. One WORD_BITS word is assembled per MISO line per SPI
// frame. Good frames are presented with a single-cycle valid strobe, and
// malformed frames raise a single-cycle frame_err strobe instead.
//
// Ports
//   clk           system clock, at least 4x the SCLK frequency
//   rst_n         asynchronous active-low reset
//   SCLK          SPI clock as driven to the headstages (asynchronous)
//   CS            SPI chip select, active-low (asynchronous)
//   MISO1, MISO2  per-port MISO lines, bit 0 = port A
//   sample_delay  clk cycles from a detected SCLK rise to the MISO sample
//   data1, data2  received words, port p at [p*WORD_BITS +: WORD_BITS]
//   valid         one-cycle strobe: data1/data2 hold a new good frame
//   frame_err     one-cycle strobe: the frame just ended malformed
//   frame_count   number of good frames received, wraps at 16 bits
module rhd_miso_deserializer #(
  parameter int N_PORTS   = 8,
  parameter int WORD_BITS = 16,
  parameter int DELAY_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           SCLK,
  input  logic                           CS,
  input  logic [N_PORTS-1:0]             MISO1,
  input  logic [N_PORTS-1:0]             MISO2,
  input  logic [DELAY_W-1:0]             sample_delay,
  output logic [N_PORTS*WORD_BITS-1:0]   data1,
  output logic [N_PORTS*WORD_BITS-1:0]   data2,
  output logic                           valid,
  output logic                           frame_err,
  output logic [15:0]                    frame_count
);

  // bit_cnt saturates one step past a full word, so it can tell
  // "exactly WORD_BITS" apart from "too many".
  localparam int                CNT_W    = $clog2(WORD_BITS + 2);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0]  SAT_CNT  = CNT_W'(WORD_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Synchronizers. Index 0 is the first flop and index 1 is the synced value.
  // Index 2 is the history flop used for edge detection on SCLK and CS.
  // MISO uses the same two-flop depth, so it stays aligned with SCLK.
  logic [2:0]         sclk_sync;
  logic [2:0]         cs_sync;
  logic [N_PORTS-1:0] miso1_meta, miso1_sync;
  logic [N_PORTS-1:0] miso2_meta, miso2_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync  <= 3'b000;
      cs_sync    <= 3'b111;
      miso1_meta <= '0;
      miso1_sync <= '0;
      miso2_meta <= '0;
      miso2_sync <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[1:0], SCLK};
      cs_sync    <= {cs_sync[1:0], CS};
      miso1_meta <= MISO1;
      miso1_sync <= miso1_meta;
      miso2_meta <= MISO2;
      miso2_sync <= miso2_meta;
    end
  end

  logic sclk_rise;
  logic cs_rise;
  logic cs_low;

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  // IDLE starts a frame on the CS level rather than on a one-cycle fall
  // pulse. A fall that arrives while the FSM sits in DONE is then still
  // taken up on the next IDLE cycle.
  assign cs_low    = ~cs_sync[1];

  state_t                               state, state_n;
  logic [CNT_W-1:0]                     bit_cnt, bit_cnt_n;
  logic [DELAY_W-1:0]                   wait_cnt, wait_cnt_n;
  logic                                 pending, pending_n;
  logic                                 err, err_n;
  logic [N_PORTS-1:0][WORD_BITS-1:0]    shift1, shift1_n;
  logic [N_PORTS-1:0][WORD_BITS-1:0]    shift2, shift2_n;
  logic [N_PORTS*WORD_BITS-1:0]         data1_n, data2_n;
  logic                                 valid_n, frame_err_n;
  logic [15:0]                          count_n;

  // Frame state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      pending     <= 1'b0;
      err         <= 1'b0;
      shift1      <= '0;
      shift2      <= '0;
      data1       <= '0;
      data2       <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      wait_cnt    <= wait_cnt_n;
      pending     <= pending_n;
      err         <= err_n;
      shift1      <= shift1_n;
      shift2      <= shift2_n;
      data1       <= data1_n;
      data2       <= data2_n;
      valid       <= valid_n;
      frame_err   <= frame_err_n;
      frame_count <= count_n;
    end
  end

  // wait_cnt holds the number of cycles still to wait *after* the current
  // one. A sample therefore lands exactly sample_delay cycles after the
  // SCLK rise is detected, and in the same cycle when sample_delay is 0.
  always_comb begin
    logic take;
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    wait_cnt_n  = wait_cnt;
    pending_n   = pending;
    err_n       = err;
    shift1_n    = shift1;
    shift2_n    = shift2;
    data1_n     = data1;
    data2_n     = data2;
    count_n     = frame_count;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    take        = 1'b0;

    case (state)
      IDLE: begin
        if (cs_low) begin
          bit_cnt_n  = '0;
          wait_cnt_n = '0;
          pending_n  = 1'b0;
          err_n      = 1'b0;
          shift1_n   = '0;
          shift2_n   = '0;
          state_n    = SHIFT;
        end
      end

      SHIFT: begin
        if (sclk_rise) begin
          // A new rise while a sample is still pending is an overrun. The
          // old sample is dropped and the delay restarts for the new rise.
          if (pending) begin
            err_n = 1'b1;
          end
          if (sample_delay == '0) begin
            take      = 1'b1;
            pending_n = 1'b0;
          end else begin
            pending_n  = 1'b1;
            wait_cnt_n = sample_delay - DELAY_W'(1);
          end
        end else if (pending) begin
          if (wait_cnt == '0) begin
            take      = 1'b1;
            pending_n = 1'b0;
          end else begin
            wait_cnt_n = wait_cnt - DELAY_W'(1);
          end
        end

        if (take) begin
          for (int p = 0; p < N_PORTS; p++) begin
            shift1_n[p] = {shift1[p][WORD_BITS-2:0], miso1_sync[p]};
            shift2_n[p] = {shift2[p][WORD_BITS-2:0], miso2_sync[p]};
          end
          if (bit_cnt != SAT_CNT) begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end

        // A sample falling due in the same cycle as the CS rise has already
        // been taken above, so DONE judges the completed count.
        if (cs_rise) begin
          state_n = DONE;
        end
      end

      DONE: begin
        if (bit_cnt == FULL_CNT && !err && !pending) begin
          data1_n = shift1;
          data2_n = shift2;
          valid_n = 1'b1;
          count_n = frame_count + 16'd1;
        end else begin
          frame_err_n = 1'b1;
        end
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rhd_miso_deserializer.sv
// tb_rhd_miso_deserializer
// Self-checking bench for rhd_miso_deserializer.
//
// Each frame is played back one clk slot at a time. The bench records the
// MISO pin values driven in every slot and the slots in which SCLK rose.
// The reference model applies the receive rules directly to that record:
// - bit k of a word is the MISO level driven sample_delay slots after the
//   k-th SCLK rise;
// - a frame is good only with exactly WORD_BITS rises, no rise arriving
//   while the previous sample is still waiting, and the last sample due no
//   later than the CS rise.
module tb_rhd_miso_deserializer;

  localparam int N_PORTS   = 8;
  localparam int WORD_BITS = 16;
  localparam int DELAY_W   = 4;
  localparam int W         = N_PORTS * WORD_BITS;
  localparam int MAX_SLOTS = 512;
  localparam int LEAD      = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 SCLK = 1'b0;
  logic                 CS = 1'b1;
  logic [N_PORTS-1:0]   MISO1 = '0;
  logic [N_PORTS-1:0]   MISO2 = '0;
  logic [DELAY_W-1:0]   sample_delay = '0;
  logic [W-1:0]         data1, data2;
  logic                 valid, frame_err;
  logic [15:0]          frame_count;

  int vectors = 0;
  int miscompares = 0;

  // Model state that persists across frames.
  logic [W-1:0] exp_data1 = '0;
  logic [W-1:0] exp_data2 = '0;
  logic [15:0]  exp_count = '0;

  // Per-frame record.
  logic [N_PORTS-1:0]   hist1 [MAX_SLOTS];
  logic [N_PORTS-1:0]   hist2 [MAX_SLOTS];
  int                   rise_q[$];
  int                   cs_rise_slot;
  int                   cur_delay;
  int                   valid_pulses;
  int                   err_pulses;
  int                   strobe_slot;
  logic [WORD_BITS-1:0] words1 [N_PORTS];
  logic [WORD_BITS-1:0] words2 [N_PORTS];

  rhd_miso_deserializer #(
    .N_PORTS   (N_PORTS),
    .WORD_BITS (WORD_BITS),
    .DELAY_W   (DELAY_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SCLK         (SCLK),
    .CS           (CS),
    .MISO1        (MISO1),
    .MISO2        (MISO2),
    .sample_delay (sample_delay),
    .data1        (data1),
    .data2        (data2),
    .valid        (valid),
    .frame_err    (frame_err),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe(input int t);
    if (valid === 1'b1) begin
      valid_pulses++;
      strobe_slot = t;
    end
    if (frame_err === 1'b1) begin
      err_pulses++;
      strobe_slot = t;
    end
  endtask

  task automatic randomWords();
    for (int p = 0; p < N_PORTS; p++) begin
      words1[p] = WORD_BITS'($urandom);
      words2[p] = WORD_BITS'($urandom);
    end
  endtask

  // Plays one frame. SCLK has half period h. MISO bit b appears lag slots
  // after the b-th SCLK fall, with bit 0 appearing at the CS fall. A
  // non-zero abort_bits pulls reset after that many SCLK pulses.
  task automatic applyStimulus(input int n_pulses, input int h, input int lag,
                               input int dly, input int abort_bits);
    int   c;
    int   falls;
    logic sclk_lvl;
    sample_delay = DELAY_W'(dly);
    cur_delay    = dly;
    rise_q.delete();
    valid_pulses = 0;
    err_pulses   = 0;
    strobe_slot  = -1;
    c = LEAD + (n_pulses - 1) * 2 * h + 2 * h;
    cs_rise_slot = c;
    for (int t = 0; t <= c + 12; t++) begin
      @(negedge clk);
      observe(t);
      if (abort_bits > 0 && t == LEAD + abort_bits * 2 * h) begin
        rst_n = 1'b0;
        #1;
        exp_data1 = '0;
        exp_data2 = '0;
        exp_count = '0;
        checkOutput("rst_mid_data1", data1, exp_data1);
        checkOutput("rst_mid_data2", data2, exp_data2);
        checkOutput("rst_mid_count", W'(frame_count), W'(exp_count));
        checkOutput("rst_mid_strobes", W'({valid, frame_err}), W'(0));
        SCLK  = 1'b0;
        CS    = 1'b1;
        MISO1 = '0;
        MISO2 = '0;
        repeat (6) begin
          @(negedge clk);
          observe(-1);
        end
        rst_n = 1'b1;
        repeat (12) begin
          @(negedge clk);
          observe(-1);
        end
        checkOutput("rst_mid_no_valid", W'(valid_pulses), W'(0));
        checkOutput("rst_mid_no_err", W'(err_pulses), W'(0));
        return;
      end
      sclk_lvl = 1'b0;
      falls = 0;
      for (int k = 0; k < n_pulses; k++) begin
        if (t >= LEAD + k * 2 * h && t < LEAD + k * 2 * h + h) sclk_lvl = 1'b1;
        if (t == LEAD + k * 2 * h) rise_q.push_back(t);
        if (LEAD + k * 2 * h + h <= t - lag) falls++;
      end
      for (int p = 0; p < N_PORTS; p++) begin
        MISO1[p] = (t >= lag && falls < WORD_BITS) ? words1[p][WORD_BITS-1-falls] : 1'b0;
        MISO2[p] = (t >= lag && falls < WORD_BITS) ? words2[p][WORD_BITS-1-falls] : 1'b0;
      end
      hist1[t] = MISO1;
      hist2[t] = MISO2;
      SCLK = sclk_lvl;
      CS   = (t >= c) ? 1'b1 : 1'b0;
    end
    SCLK  = 1'b0;
    MISO1 = '0;
    MISO2 = '0;
  endtask

  // Reference model for the frame just played, followed by the comparisons.
  task automatic checkFrame(input string tag);
    logic good;
    good = (rise_q.size() == WORD_BITS);
    for (int i = 1; i < rise_q.size(); i++) begin
      if (cur_delay > 0 && rise_q[i] - rise_q[i-1] <= cur_delay) good = 1'b0;
    end
    if (rise_q.size() > 0 && rise_q[rise_q.size()-1] + cur_delay > cs_rise_slot) good = 1'b0;
    if (good) begin
      for (int p = 0; p < N_PORTS; p++) begin
        for (int k = 0; k < WORD_BITS; k++) begin
          exp_data1[p*WORD_BITS + WORD_BITS-1-k] = hist1[rise_q[k] + cur_delay][p];
          exp_data2[p*WORD_BITS + WORD_BITS-1-k] = hist2[rise_q[k] + cur_delay][p];
        end
      end
      exp_count = exp_count + 16'd1;
    end
    checkOutput({tag, "_valid_pulses"}, W'(valid_pulses), W'(good ? 1 : 0));
    checkOutput({tag, "_err_pulses"}, W'(err_pulses), W'(good ? 0 : 1));
    checkOutput({tag, "_strobe_latency"}, W'(strobe_slot), W'(cs_rise_slot + 4));
    checkOutput({tag, "_data1"}, data1, exp_data1);
    checkOutput({tag, "_data2"}, data2, exp_data2);
    checkOutput({tag, "_count"}, W'(frame_count), W'(exp_count));
  endtask

  initial begin
    int n, h, lag, dly;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_data1", data1, '0);
    checkOutput("reset_data2", data2, '0);
    checkOutput("reset_valid", W'(valid), W'(0));
    checkOutput("reset_frame_err", W'(frame_err), W'(0));
    checkOutput("reset_count", W'(frame_count), W'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed good frame with fixed words, data changing on SCLK fall.
    for (int p = 0; p < N_PORTS; p++) begin
      words1[p] = 16'hA5C3 + 16'(p);
      words2[p] = ~words1[p];
    end
    applyStimulus(16, 4, 0, 0, 0);
    checkFrame("good");
    checkOutput("good_portA_miso1", W'(data1[15:0]), W'(16'hA5C3));
    checkOutput("good_portH_miso1", W'(data1[127:112]), W'(16'hA5CA));
    checkOutput("good_portA_miso2", W'(data2[15:0]), W'(16'h5A3C));
    checkOutput("good_count_one", W'(frame_count), W'(1));

    // Delay compensation: the MISO change lands 3 clk after the next SCLK
    // rise. A sample delay of 4 recovers the words; 0 gives a shifted word.
    randomWords();
    applyStimulus(16, 4, 7, 4, 0);
    checkFrame("delay4");
    randomWords();
    applyStimulus(16, 4, 7, 0, 0);
    checkFrame("delay0");

    // Short and long frames.
    randomWords();
    applyStimulus(15, 4, 0, 0, 0);
    checkFrame("short15");
    randomWords();
    applyStimulus(17, 4, 0, 0, 0);
    checkFrame("long17");

    // Overrun: the sample delay exceeds the SCLK period.
    randomWords();
    applyStimulus(16, 4, 0, 15, 0);
    checkFrame("overrun");

    // Reset after 8 bits, then a clean frame.
    randomWords();
    applyStimulus(16, 4, 0, 0, 8);
    randomWords();
    applyStimulus(16, 4, 0, 0, 0);
    checkFrame("after_reset");
    checkOutput("after_reset_count_one", W'(frame_count), W'(1));

    // Randomized frames.
    for (int i = 0; i < 12; i++) begin
      h   = $urandom_range(2, 5);
      lag = $urandom_range(0, 2 * h + 2);
      dly = $urandom_range(0, 2 * h + 1);
      n   = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 15 : 17) : 16;
      randomWords();
      applyStimulus(n, h, lag, dly, 0);
      checkFrame($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rhd_miso_deserializer.md
Name: rhd_miso_deserializer

Overview:
- Host-side receive stage that sits directly downstream of the headstage MISO lines.
- Oversamples SCLK, CS and the MISO1/MISO2 pair of every port in the `clk` domain. Compensates cable/headstage delay with a programmable sample delay.
- Assembles one 16-bit word per MISO line per SPI frame and presents all words with a single-cycle valid strobe.
- Flags malformed frames: wrong bit count, sample overrun, CS deasserted mid-sample.

Parameters:
- N_PORTS, 8, number of headstage ports (A..H); each port has MISO1 and MISO2.
- WORD_BITS, 16, SCLK rising edges per well-formed frame.
- DELAY_W, 4, width of sample_delay.

Ports:
- clk  input  1  system clock; must be at least 4x SCLK frequency.
- rst_n  input  1  asynchronous active-low reset.
- SCLK  input  1  SPI clock as driven to the headstages (asynchronous to clk).
- CS  input  1  SPI chip select, active-low (asynchronous).
- MISO1  input  N_PORTS  MISO1 line per port, bit 0 = port A.
- MISO2  input  N_PORTS  MISO2 line per port.
- sample_delay  input  DELAY_W  clk cycles from detected SCLK rise to MISO sample; quasi-static, only changed while CS is high.
- data1  output  N_PORTS*WORD_BITS  MISO1 words; port p at [p*16+15 : p*16].
- data2  output  N_PORTS*WORD_BITS  MISO2 words, same packing.
- valid  output  1  one-cycle strobe; data1/data2 hold a new good frame.
- frame_err  output  1  one-cycle strobe; frame ended malformed.
- frame_count  output  16  count of good frames; wraps.

Behaviour:
- Reset (async assert, sync release): data1 = 0, data2 = 0, valid = 0, frame_err = 0, frame_count = 0. FSM goes to IDLE; synchronizers reset to SCLK = 0, CS = 1, MISO = 0.
- Synchronization:
  - SCLK, CS, MISO1 and MISO2 each pass through a 2-flop synchronizer.
  - SCLK and CS get one further history flop for edge detection.
  - An edge is seen 3 clk cycles after the pin transition.
  - MISO takes the same 2-flop path, so relative alignment is preserved.
- FSM state IDLE:
  - On synced CS fall: clear bit_cnt, shift registers and the err flag; go to SHIFT.
- FSM state SHIFT:
  - On synced SCLK rise: load delay counter with sample_delay and set pending.
  - When pending and the counter is 0: shift all 2*N_PORTS synced MISO bits in MSB-first (first sampled bit ends at bit 15). Clear pending; bit_cnt++ saturating at WORD_BITS+1.
  - sample_delay = 0: sample taken in the same cycle the rise is detected.
  - SCLK rise while pending: set err. The pending sample is dropped, bit_cnt is not incremented, and the delay restarts for the new edge.
  - On synced CS rise: go to DONE.
  - If CS rise and a sample both fall due in the same cycle, the sample is taken first, then DONE.
- FSM state DONE (exactly one cycle):
  - Good frame = bit_cnt == WORD_BITS, err clear, no pending. Then:
    - copy the shift registers to data1/data2;
    - assert valid for 1 cycle;
    - frame_count++ (0xFFFF wraps to 0x0000).
  - Otherwise (including a pending sample discarded by the CS rise): assert frame_err for 1 cycle; data1, data2 and frame_count are unchanged.
  - Go to IDLE.
- Latency: valid is asserted 4 clk cycles after the CS pin rise (3 sync/edge + 1 DONE).
- CS fall detected while in DONE: accepted on the following IDLE cycle. A CS high time of at least 2 clk cycles is guaranteed by the master.
- SCLK edges while CS is high are ignored.
- valid and frame_err are never asserted together.
- Reset mid-frame: all state is cleared immediately; no strobe is produced for the aborted frame.

Test Plan:
- Good frame: sample_delay = 0; ports A..H MISO1 = 0xA5C3 + p, MISO2 = ~MISO1, data changing on SCLK fall; 16 SCLK pulses inside CS low. Expected: valid = 1 for one cycle, 4 clk after CS rise; data1[15:0] = 0xA5C3, data1[127:112] = 0xA5CA, data2[15:0] = 0x5A3C; frame_count = 1.
- Delay compensation: MISO delayed by 3 clk relative to SCLK; sample_delay = 4 gives correct words. sample_delay = 0 gives a shifted or corrupted word, with no frame_err.
- Short and long frames: 15 SCLK pulses gives frame_err = 1, valid = 0, data/count unchanged. 17 pulses also gives frame_err = 1.
- Overrun: sample_delay = 15 with SCLK period = 8 clk gives frame_err = 1.
- Reset mid-frame: assert rst_n = 0 after 8 bits. Expected: outputs 0 immediately; no strobe. The next full frame is received correctly with frame_count = 1.
- Counter wrap: 65536 good frames. Expected: frame_count returns to 0x0000; valid pulses exactly 65536 times.
